tvout_gen: RTL and testbench

Parametrised composite-video raster generator, successor to the fixed 512×288 border-test TV output. Divides the system clock to a pixel tick, runs horizontal/vertical counters with configurable totals, active area and sync windows, and produces a combined active-low sync plus multi-bit video. Video comes either from an external synchronous framebuffer RAM through a one-cycle fetch pipeline or from a built-in test pattern, selected once per frame. Sits between the framebuffer and the external resistor DAC / sync pins.

---
 rtl/tvout_gen.sv | 122 ++++++++++++
 tb/tb_tvout_gen.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/tvout_gen.sv
// rtl/tvout_gen.sv - composite-video raster generator with framebuffer fetch or built-in test pattern
module tvout_gen #(
  parameter int CLK_DIV     = 5,
  parameter int H_TOTAL     = 640,
  parameter int H_ACTIVE    = 512,
  parameter int HSYNC_START = 533,
  parameter int HSYNC_END   = 580,
  parameter int V_TOTAL     = 309,
  parameter int V_ACTIVE    = 288,
  parameter int VSYNC_START = 290,
  parameter int VSYNC_END   = 292,
  parameter int DW          = 1,
  parameter int XW          = $clog2(H_ACTIVE),
  parameter int YW          = $clog2(V_ACTIVE),
  parameter int AW          = XW + YW
) (
  input  logic          clk,
  input  logic          rst_,
  input  logic          pattern,
  output logic          rd_en,
  output logic [AW-1:0] rd_addr,
  input  logic [DW-1:0] rd_data,
  output logic [DW-1:0] vout,
  output logic          sync_,
  output logic          pix_tick,
  output logic          frame_start
);
  localparam int DVW = $clog2(CLK_DIV);
  localparam int HCW = $clog2(H_TOTAL);
  localparam int VCW = $clog2(V_TOTAL);

  logic [DVW-1:0] div_q, div_d;
  logic [HCW-1:0] x_q, x_d;
  logic [VCW-1:0] y_q, y_d;
  logic           mode_q, mode_d;
  logic           act_o_q, act_o_d;
  logic           mode_o_q, mode_o_d;
  logic           pat_o_q, pat_o_d;
  logic           sync_q, sync_d;
  logic           fs_q, fs_d;
  logic           load_q, load_d;
  logic [DW-1:0]  hold_q, hold_d;

  logic           tick, active, hsync, vsync, origin, mode_cur, pat_bit;
  logic [DW-1:0]  vout_live;

  always_comb begin
    tick     = rst_ && (div_q == '0);
    active   = (x_q < HCW'(H_ACTIVE)) && (y_q < VCW'(V_ACTIVE));
    hsync    = (x_q >= HCW'(HSYNC_START)) && (x_q < HCW'(HSYNC_END));
    vsync    = ((y_q >= VCW'(VSYNC_START)) && (y_q < VCW'(VSYNC_END))) ||
               ((y_q == VCW'(VSYNC_END)) && (x_q < HCW'(H_TOTAL / 2)));
    origin   = (x_q == '0) && (y_q == '0);
    // The frame's source is chosen at its first tick, so pixel (0,0) already uses the new mode.
    mode_cur = (tick && origin) ? pattern : mode_q;
    pat_bit  = (x_q == '0) || (x_q == HCW'(H_ACTIVE - 1)) ||
               (y_q == '0) || (y_q == VCW'(V_ACTIVE - 1)) || (x_q[3] ^ y_q[3]);
    vout_live = act_o_q ? (mode_o_q ? {DW{pat_o_q}} : rd_data) : '0;

    div_d    = (div_q == DVW'(CLK_DIV - 1)) ? '0 : div_q + 1'b1;
    x_d      = x_q;
    y_d      = y_q;
    mode_d   = mode_q;
    act_o_d  = act_o_q;
    mode_o_d = mode_o_q;
    pat_o_d  = pat_o_q;
    sync_d   = sync_q;
    fs_d     = tick && origin;
    load_d   = tick;
    hold_d   = load_q ? vout_live : hold_q;

    if (tick) begin
      if (x_q == HCW'(H_TOTAL - 1)) begin
        x_d = '0;
        y_d = (y_q == VCW'(V_TOTAL - 1)) ? '0 : y_q + 1'b1;
      end else begin
        x_d = x_q + 1'b1;
      end
      mode_d   = mode_cur;
      act_o_d  = active;
      mode_o_d = mode_cur;
      pat_o_d  = pat_bit;
      sync_d   = !(hsync || vsync);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_) begin
      div_q    <= '0;
      x_q      <= '0;
      y_q      <= '0;
      mode_q   <= 1'b0;
      act_o_q  <= 1'b0;
      mode_o_q <= 1'b0;
      pat_o_q  <= 1'b0;
      sync_q   <= 1'b1;
      fs_q     <= 1'b0;
      load_q   <= 1'b0;
      hold_q   <= '0;
    end else begin
      div_q    <= div_d;
      x_q      <= x_d;
      y_q      <= y_d;
      mode_q   <= mode_d;
      act_o_q  <= act_o_d;
      mode_o_q <= mode_o_d;
      pat_o_q  <= pat_o_d;
      sync_q   <= sync_d;
      fs_q     <= fs_d;
      load_q   <= load_d;
      hold_q   <= hold_d;
    end
  end

  // RAM data arrives in the clk after the tick; it is shown live then and held for the rest of the pixel.
  assign vout        = load_q ? vout_live : hold_q;
  assign rd_en       = tick && active && !mode_cur;
  assign rd_addr     = {y_q[YW-1:0], x_q[XW-1:0]};
  assign sync_       = sync_q;
  assign pix_tick    = tick;
  assign frame_start = fs_q;
endmodule

// File: tb/tb_tvout_gen.sv
// tb/tb_tvout_gen.sv - self-checking bench for tvout_gen on a scaled-down raster
module tb_tvout_gen;
  localparam int CD = 3;
  localparam int HT = 40;
  localparam int HA = 32;
  localparam int HS = 34;
  localparam int HE = 37;
  localparam int VT = 24;
  localparam int VA = 16;
  localparam int VS = 18;
  localparam int VE = 20;
  localparam int DW = 2;
  localparam int FR = HT * VT;

  logic          clk = 1'b0;
  logic          rst_;
  logic          pattern;
  logic          rd_en;
  logic [8:0]    rd_addr;
  logic [DW-1:0] rd_data;
  logic [DW-1:0] vout;
  logic          sync_;
  logic          pix_tick;
  logic          frame_start;

  always #5 clk = ~clk;

  tvout_gen #(
    .CLK_DIV(CD), .H_TOTAL(HT), .H_ACTIVE(HA), .HSYNC_START(HS), .HSYNC_END(HE),
    .V_TOTAL(VT), .V_ACTIVE(VA), .VSYNC_START(VS), .VSYNC_END(VE), .DW(DW)
  ) dut (
    .clk(clk), .rst_(rst_), .pattern(pattern), .rd_en(rd_en), .rd_addr(rd_addr),
    .rd_data(rd_data), .vout(vout), .sync_(sync_), .pix_tick(pix_tick),
    .frame_start(frame_start)
  );

  // RAM returns the low address bits when read, garbage otherwise.
  always @(posedge clk) rd_data <= rd_en ? rd_addr[1:0] : 2'($urandom);

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s at %0t: got=%0h want=%0h", name, $time, got, want);
    end
  endtask

  function automatic logic pbit(input int x, input int y);
    if (x == 0 || x == HA - 1 || y == 0 || y == VA - 1) return 1'b1;
    return 1'(((x >> 3) & 1) ^ ((y >> 3) & 1));
  endfunction

  function automatic logic in_sync(input int x, input int y);
    return (x >= HS && x < HE) || (y >= VS && y < VE) || (y == VE && x < HT / 2);
  endfunction

  // Model: t counts clks since the last reset edge; a pixel lasts CD clks.
  int   t = -1;
  logic cur_mode = 1'b0;
  always @(posedge clk) begin
    if (!rst_) begin
      t <= 0;
      cur_mode <= 1'b0;
    end else begin
      t <= t + 1;
      if (t >= 0 && t % CD == 0 && (t / CD) % FR == 0) cur_mode <= pattern;
    end
  end

  int         lo_cnt [8][VT];
  int         rd_cnt [8][VT];
  logic [1:0] cap    [8][VA][HA];

  always @(negedge clk) begin
    int q, x, y, px, py, f, u;
    logic tk, mrd, act, e_rd;
    logic [DW-1:0] e_vout;
    if (t >= 0) begin
      tk   = rst_ && (t % CD == 0);
      px   = (t / CD) % HT;
      py   = (t / CD / HT) % VT;
      act  = px < HA && py < VA;
      mrd  = (tk && px == 0 && py == 0) ? pattern : cur_mode;
      e_rd = tk && act && !mrd;
      chk("pix_tick", 32'(pix_tick), 32'(tk));
      chk("rd_en", 32'(rd_en), 32'(e_rd));
      if (e_rd) chk("rd_addr", 32'(rd_addr), 32'({py[3:0], px[4:0]}));
      if (rd_en === 1'b1) begin
        f = (t / CD) / FR;
        if (f < 8) rd_cnt[f][py]++;
      end
      if (t == 0) begin
        chk("vout_rst", 32'(vout), 32'd0);
        chk("sync_rst", 32'(sync_), 32'd1);
        chk("fs_rst", 32'(frame_start), 32'd0);
      end else begin
        q = (t - 1) / CD;
        u = (t - 1) % CD;
        x = q % HT;
        y = (q / HT) % VT;
        f = q / FR;
        if (x < HA && y < VA) e_vout = cur_mode ? {DW{pbit(x, y)}} : x[1:0];
        else                  e_vout = '0;
        chk("vout", 32'(vout), 32'(e_vout));
        chk("sync_", 32'(sync_), 32'(!in_sync(x, y)));
        chk("frame_start", 32'(frame_start), 32'(u == 0 && q % FR == 0));
        if (f < 8) begin
          if (sync_ === 1'b0) lo_cnt[f][y]++;
          if (u == 0 && x < HA && y < VA) cap[f][y][x] = vout;
        end
      end
    end
  end

  task automatic wait_pix(input int f, input int x, input int y);
    int n;
    n = 0;
    while (!(t >= 0 && rst_ && t % CD == 0 && t / CD == f * FR + y * HT + x) && n < 20000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 20000) begin
      checks++;
      failures++;
      $display("FAIL wait_pix timeout f=%0d x=%0d y=%0d", f, x, y);
    end
  endtask

  task automatic fs_latency(output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (frame_start !== 1'b1 && n < 5000);
  endtask

  initial begin
    int n, sum;
    rst_ = 1'b0;
    pattern = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    chk("reset_vout", 32'(vout), 32'd0);
    chk("reset_sync", 32'(sync_), 32'd1);
    chk("reset_fs", 32'(frame_start), 32'd0);
    chk("reset_rd_en", 32'(rd_en), 32'd0);
    rst_ = 1'b1;
    @(posedge clk);
    fs_latency(n);
    chk("first_fs_latency", 32'(n), 32'd1);
    fs_latency(n);
    chk("frame_period", 32'(n), 32'(FR * CD));

    wait_pix(1, 0, 5);
    @(posedge clk); #1 pattern = 1'b1;
    wait_pix(2, 0, 8);
    @(posedge clk); #1 pattern = 1'b0;
    wait_pix(4, 0, 0);

    chk("line10_sync_low", 32'(lo_cnt[0][10]), 32'd9);
    chk("line10_rd_count", 32'(rd_cnt[0][10]), 32'd32);
    chk("line18_sync_low", 32'(lo_cnt[0][18]), 32'd120);
    chk("line19_sync_low", 32'(lo_cnt[0][19]), 32'd120);
    chk("line20_sync_low", 32'(lo_cnt[0][20]), 32'd69);
    chk("line21_sync_low", 32'(lo_cnt[0][21]), 32'd9);
    chk("fb_px_5_3", 32'(cap[0][3][5]), 32'd1);
    chk("fb_px_2_0", 32'(cap[0][0][2]), 32'd2);
    chk("fb_midchange_px_6_12", 32'(cap[1][12][6]), 32'd2);
    chk("pat_px_0_5", 32'(cap[2][5][0]), 32'd3);
    chk("pat_px_8_0", 32'(cap[2][0][8]), 32'd3);
    chk("pat_px_8_8", 32'(cap[2][8][8]), 32'd0);
    chk("pat_px_8_3", 32'(cap[2][3][8]), 32'd3);
    chk("pat_px_30_9", 32'(cap[2][9][30]), 32'd0);
    sum = 0;
    for (int i = 0; i < VT; i++) sum += rd_cnt[2][i];
    chk("pat_frame_no_rd", 32'(sum), 32'd0);
    chk("fb_back_rd_count", 32'(rd_cnt[3][10]), 32'd32);
    chk("fb_back_px_5_3", 32'(cap[3][3][5]), 32'd1);

    wait_pix(4, 5, 10);
    @(posedge clk); #1;
    chk("pre_reset_vout", 32'(vout), 32'd1);
    rst_ = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("midreset_vout", 32'(vout), 32'd0);
    chk("midreset_sync", 32'(sync_), 32'd1);
    @(posedge clk);
    @(posedge clk); #1;
    rst_ = 1'b1;
    @(posedge clk);
    fs_latency(n);
    chk("restart_fs_latency", 32'(n), 32'd1);
    wait_pix(1, 0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end
endmodule
